// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared state, status and format constants for the fp add/sub block
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADDSUB,
    NORM,
    ROUND,
    DONE
  } fp_state_e;

  localparam int ST_EXACT     = 0;
  localparam int ST_INEXACT   = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 3;
  localparam int ST_INVALID   = 4;
  localparam int STATUS_W     = 5;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  function automatic logic [STATUS_W-1:0] status_bit(input int idx);
    return STATUS_W'(1) << idx;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter; all-zero input yields WIDTH
module fp_lzc #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_param.sv
// rtl/fp_addsub_param.sv - multi-cycle parameterised IEEE-754 adder/subtractor, RNE rounding
module fp_addsub_param
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        op_A_in,
  input  logic [W-1:0]        op_B_in,
  input  logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        data_out,
  output logic [STATUS_W-1:0] status_out
);

  // Mantissa layout: carry, hidden, fraction, guard, round, sticky.
  localparam int MW   = MAN_W + 5;
  localparam int EW   = EXP_W + 1;
  localparam int LZ_W = $clog2(MW);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  fp_state_e state, nxt;

  logic [W-1:0]        a_r, b_r;
  logic                sub_r;
  logic [EW-1:0]       exp_r;
  logic [MW-1:0]       acc_r, sml_r;
  logic                sign_r, eff_sub_r, spec_r;
  logic [W-1:0]        spec_data_r;
  logic [STATUS_W-1:0] spec_stat_r;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = ALIGN;
      ALIGN:   nxt = ADDSUB;
      ADDSUB:  nxt = NORM;
      NORM:    nxt = ROUND;
      ROUND:   nxt = DONE;
      DONE:    if (out_valid && out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  logic                sa, sb, a_big, nan_a, nan_b, inf_a, inf_b;
  logic [EXP_W-1:0]    ea, eb, el, es, el_eff, es_eff;
  logic [MAN_W-1:0]    fa, fb, fl, fs;
  logic [MW-1:0]       ml, ms, ms_sh;
  logic [31:0]         diff, shamt;
  logic [W-1:0]        spec_data;
  logic [STATUS_W-1:0] spec_stat;

  always_comb begin
    sa = a_r[W-1];
    sb = b_r[W-1] ^ sub_r;
    ea = a_r[W-2:MAN_W];
    eb = b_r[W-2:MAN_W];
    fa = a_r[MAN_W-1:0];
    fb = b_r[MAN_W-1:0];
    // Comparing {exp, frac} orders magnitudes correctly, subnormals included.
    a_big  = {ea, fa} >= {eb, fb};
    el     = a_big ? ea : eb;
    es     = a_big ? eb : ea;
    fl     = a_big ? fa : fb;
    fs     = a_big ? fb : fa;
    el_eff = (el == '0) ? EXP_W'(1) : el;
    es_eff = (es == '0) ? EXP_W'(1) : es;
    ml     = {1'b0, el != '0, fl, 3'b000};
    ms     = {1'b0, es != '0, fs, 3'b000};
    diff   = 32'(el_eff) - 32'(es_eff);
    shamt  = (diff > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : diff;
    ms_sh  = ms >> shamt;
    ms_sh[0] = ms_sh[0] | (|(ms & ~({MW{1'b1}} << shamt)));

    nan_a = (ea == EXP_ONES) && (fa != '0);
    nan_b = (eb == EXP_ONES) && (fb != '0);
    inf_a = (ea == EXP_ONES) && (fa == '0);
    inf_b = (eb == EXP_ONES) && (fb == '0);
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      spec_data = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      spec_stat = status_bit(ST_INVALID);
    end else if (inf_a) begin
      spec_data = {sa, EXP_ONES, {MAN_W{1'b0}}};
      spec_stat = status_bit(ST_EXACT);
    end else begin
      spec_data = {sb, EXP_ONES, {MAN_W{1'b0}}};
      spec_stat = status_bit(ST_EXACT);
    end
  end

  logic [LZ_W-1:0] lz;
  logic [31:0]     lim, sh;
  logic [MW-1:0]   sum, n_man;
  logic [EW-1:0]   n_exp;

  fp_lzc #(.WIDTH(MW - 1)) u_lzc (
    .din (acc_r[MW-2:0]),
    .cnt (lz)
  );

  always_comb begin
    sum = eff_sub_r ? (acc_r - sml_r) : (acc_r + sml_r);
    // Left shift stops at exponent 1 so tiny results come out subnormal.
    lim = 32'(exp_r) - 32'd1;
    sh  = (32'(lz) < lim) ? 32'(lz) : lim;
    if (acc_r[MW-1]) begin
      n_man = {1'b0, acc_r[MW-1:2], acc_r[1] | acc_r[0]};
      n_exp = exp_r + EW'(1);
    end else begin
      n_man = acc_r << sh;
      n_exp = exp_r - EW'(sh);
    end
  end

  logic                inexact, r_carry, r_hid, r_sign;
  logic [MAN_W+1:0]    rnd;
  logic [EW-1:0]       r_exp;
  logic [MAN_W-1:0]    r_frac;
  logic [W-1:0]        res;
  logic [STATUS_W-1:0] res_stat;

  always_comb begin
    inexact = |acc_r[2:0];
    rnd     = {1'b0, acc_r[MAN_W+3:3]}
            + (MAN_W+2)'(acc_r[2] & (acc_r[1] | acc_r[0] | acc_r[3]));
    r_carry = rnd[MAN_W+1];
    r_exp   = exp_r + EW'(r_carry);
    r_frac  = r_carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    r_hid   = r_carry | rnd[MAN_W];
    r_sign  = (!inexact && (rnd == '0) && eff_sub_r) ? 1'b0 : sign_r;
    if (spec_r) begin
      res      = spec_data_r;
      res_stat = spec_stat_r;
    end else if (r_hid && (r_exp >= EW'(EXP_ONES))) begin
      res      = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      res_stat = status_bit(ST_OVERFLOW);
    end else begin
      res = {r_sign, (r_hid ? r_exp[EXP_W-1:0] : {EXP_W{1'b0}}), r_frac};
      if (!r_hid && inexact) res_stat = status_bit(ST_UNDERFLOW);
      else if (inexact)      res_stat = status_bit(ST_INEXACT);
      else                   res_stat = status_bit(ST_EXACT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sub_r       <= 1'b0;
      exp_r       <= '0;
      acc_r       <= '0;
      sml_r       <= '0;
      sign_r      <= 1'b0;
      eff_sub_r   <= 1'b0;
      spec_r      <= 1'b0;
      spec_data_r <= '0;
      spec_stat_r <= '0;
      data_out    <= '0;
      status_out  <= '0;
      out_valid   <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= op_A_in;
          b_r   <= op_B_in;
          sub_r <= op_sub;
        end
        ALIGN: begin
          exp_r       <= EW'(el_eff);
          acc_r       <= ml;
          sml_r       <= ms_sh;
          sign_r      <= a_big ? sa : sb;
          eff_sub_r   <= sa ^ sb;
          spec_r      <= nan_a | nan_b | inf_a | inf_b;
          spec_data_r <= spec_data;
          spec_stat_r <= spec_stat;
        end
        ADDSUB: acc_r <= sum;
        NORM: begin
          acc_r <= n_man;
          exp_r <= n_exp;
        end
        ROUND: begin
          data_out   <= res;
          status_out <= res_stat;
        end
        DONE: begin
          // Result is registered on entry; valid follows one edge later.
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_addsub_param.md
FP_ADDSUB_PARAM -- requirements
Module: fp_addsub_param

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (allowed range 4..11).
REQ-002 Parameter MAN_W, default 23, stored fraction width (allowed range 7..52); W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands and op_sub are valid.
REQ-006 in_ready  output  1  block accepts an operation; high only in state IDLE.
REQ-007 op_A_in  input  W  operand A in IEEE-754 layout {sign, exponent, fraction}.
REQ-008 op_B_in  input  W  operand B in the same layout.
REQ-009 op_sub  input  1  0 = A+B; 1 = A-B (B sign inverted).
REQ-010 out_valid  output  1  data_out and status_out hold a result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 data_out  output  W  rounded result.
REQ-013 status_out  output  5  one-hot: [0] EXACT, [1] INEXACT, [2] OVERFLOW, [3] UNDERFLOW, [4] INVALID.

Function
REQ-014 The FSM SHALL use states IDLE, ALIGN, ADDSUB, NORM, ROUND, DONE, advancing one state per clock.
REQ-015 An operation SHALL be accepted on an edge where in_valid && in_ready; operands and op_sub SHALL be registered on that edge.
REQ-016 out_valid SHALL rise exactly 5 edges after the accept edge; the latency SHALL NOT depend on operands.
REQ-017 In DONE, data_out/status_out SHALL stay stable until out_valid && out_ready, after which the FSM SHALL return to IDLE; no overlap between operations.
REQ-018 Exponent 0 operands SHALL be subnormal: hidden bit 0, effective exponent 1.
REQ-019 Datapath mantissa SHALL be hidden+MAN_W+guard+round+sticky plus 1 carry bit.
REQ-020 Alignment SHALL right-shift the smaller-exponent mantissa; the shift saturates at MAN_W+3, and shifted-out bits SHALL OR into sticky.
REQ-021 For effective subtraction, the larger magnitude SHALL be the minuend, and the result SHALL take its sign.
REQ-022 NORM SHALL normalise in one cycle using a leading-zero count.
REQ-023 On carry, NORM SHALL shift right 1 and increment the exponent.
REQ-024 Otherwise NORM SHALL shift left by min(lzc, exponent-1); a result with exponent 0 SHALL be emitted as subnormal (gradual underflow).
REQ-025 ROUND SHALL round to nearest, ties to even, using guard/round/sticky.
REQ-026 A mantissa carry from rounding SHALL increment the exponent, including subnormal to normal.
REQ-027 Status SHALL be one-hot with priority INVALID > OVERFLOW > UNDERFLOW > INEXACT > EXACT.
REQ-028 INEXACT SHALL mean any of G/R/S is nonzero.
REQ-029 UNDERFLOW SHALL be set when the result is tiny (subnormal or zero) and inexact.
REQ-030 A final exponent equal to all-ones SHALL produce signed infinity with OVERFLOW.
REQ-031 An exact zero from opposite-sign operands SHALL be +0; (-0)+(-0) SHALL give -0.
REQ-032 Any NaN input, or Inf-Inf, SHALL output canonical qNaN {0, all-ones, 1 followed by zeros} with INVALID.
REQ-033 Inf with a finite operand SHALL pass the signed Inf through with EXACT.

Reset
REQ-034 While reset=0: state IDLE, out_valid=0, data_out=0, status_out=0, and all datapath registers cleared.
REQ-035 An assertion of reset mid-operation SHALL abandon the operation immediately; after release in_ready=1 and no stale result appears.

Structure
REQ-036 Shared package fp_pkg SHALL hold the state enum, the status bit indices, and default EXP_W/MAN_W constants.
REQ-037 Sub-module fp_lzc SHALL be a parameterised combinational leading-zero counter used by NORM.

Verification
REQ-038 Verification SHALL cover: 0x3F800000 + 0x3F800000 -> 0x40000000 EXACT; out_valid 5 edges after accept.
REQ-039 Verification SHALL cover round ties-to-even: 0x3F800000 + 0x33800000 -> 0x3F800000 INEXACT; 0x3F800001 + 0x33800000 -> 0x3F800002 INEXACT.
REQ-040 Verification SHALL cover overflow: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 OVERFLOW; 0x7F800000 + 0xFF800000 -> 0x7FC00000 INVALID.
REQ-041 Verification SHALL cover op_sub=1 with A=B=0x40490FDB -> 0x00000000 EXACT, and 0x00800000 - 0x00400000 -> 0x00400000 EXACT (subnormal).
REQ-042 Verification SHALL cover out_ready held low 3 cycles: data_out stable and in_ready=0. Reset pulsed in ALIGN -> out_valid=0, and the next op returns a correct result.
REQ-043 Verification SHALL cover EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000 EXACT; 0x7BFF + 0x7BFF -> 0x7C00 OVERFLOW.
